// File: rtl/vga_timer_if.sv
// vga_timer_if: raster timing bundle produced by vga_timer and consumed by
// the sprite/text objects and the top-level RGB/sync output register.
interface vga_timer_if;
  logic [9:0] position_x_o;
  logic [9:0] position_y_o;
  logic       visible_o;
  logic       hsync_o;
  logic       vsync_o;
  logic       frame_start_o;

  modport master (
    output position_x_o,
    output position_y_o,
    output visible_o,
    output hsync_o,
    output vsync_o,
    output frame_start_o
  );

  modport slave (
    input position_x_o,
    input position_y_o,
    input visible_o,
    input hsync_o,
    input vsync_o,
    input frame_start_o
  );
endinterface

// File: rtl/vga_timer.sv
// vga_timer: 640x480@60 raster generator. Column/line counters plus
// registered hsync/vsync (active-low), visible flag and a frame-start pulse.
// The decoded outputs are computed from the next-state counters so they are
// cycle-aligned with position_x_o/position_y_o.
// Optional feature macro: VGA_TIMER_CLK_DIV_EN -- run from a 100 MHz clock
// with a divide-by-4 prescaler generating the 25 MHz pixel tick.
module vga_timer #(
  parameter int unsigned HVisible = 640,
  parameter int unsigned HFront   = 16,
  parameter int unsigned HSync    = 96,
  parameter int unsigned HBack    = 48,
  parameter int unsigned VVisible = 480,
  parameter int unsigned VFront   = 10,
  parameter int unsigned VSync    = 2,
  parameter int unsigned VBack    = 33
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  vga_timer_if.master vga
);

  localparam int unsigned HTotal = HVisible + HFront + HSync + HBack;
  localparam int unsigned VTotal = VVisible + VFront + VSync + VBack;

  // The counters are 10 bits wide; larger timings cannot be represented.
  if (HTotal > 1024 || VTotal > 1024) begin : gen_size_check
    $error("vga_timer: HTotal/VTotal must not exceed 1024");
  end

  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] HVisLimit  = 10'(HVisible);
  localparam logic [9:0] VVisLimit  = 10'(VVisible);
  localparam logic [9:0] HSyncFirst = 10'(HVisible + HFront);
  localparam logic [9:0] HSyncLast  = 10'(HVisible + HFront + HSync - 1);
  localparam logic [9:0] VSyncFirst = 10'(VVisible + VFront);
  localparam logic [9:0] VSyncLast  = 10'(VVisible + VFront + VSync - 1);

  logic [9:0] posX_q, posX_d;
  logic [9:0] posY_q, posY_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       visible_q, visible_d;
  logic       frameStart_q, frameStart_d;
  logic       tick;

`ifdef VGA_TIMER_CLK_DIV_EN
  logic [1:0] prescale_q;

  // Free-running divide-by-4 prescaler; the pixel tick is its terminal count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescale_q <= 2'd0;
    end else begin
      prescale_q <= prescale_q + 2'd1;
    end
  end

  assign tick = (prescale_q == 2'd3);
`else
  assign tick = 1'b1;
`endif

  // Next-state counters and the decodes derived from them. Between ticks the
  // next state equals the current state, so every decoded output holds.
  always_comb begin
    posX_d       = posX_q;
    posY_d       = posY_q;
    frameStart_d = 1'b0;
    if (tick) begin
      if (posX_q == HLast) begin
        posX_d = '0;
        if (posY_q == VLast) begin
          posY_d       = '0;
          frameStart_d = 1'b1;
        end else begin
          posY_d = posY_q + 10'd1;
        end
      end else begin
        posX_d = posX_q + 10'd1;
      end
    end
    hsync_d   = !((posX_d >= HSyncFirst) && (posX_d <= HSyncLast));
    vsync_d   = !((posY_d >= VSyncFirst) && (posY_d <= VSyncLast));
    visible_d = (posX_d < HVisLimit) && (posY_d < VVisLimit);
  end

  // Counter and decoded-output registers; reset parks the raster at (0,0)
  // without announcing a frame start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      posX_q       <= '0;
      posY_q       <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      visible_q    <= 1'b1;
      frameStart_q <= 1'b0;
    end else begin
      posX_q       <= posX_d;
      posY_q       <= posY_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      visible_q    <= visible_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign vga.position_x_o  = posX_q;
  assign vga.position_y_o  = posY_q;
  assign vga.hsync_o       = hsync_q;
  assign vga.vsync_o       = vsync_q;
  assign vga.visible_o     = visible_q;
  assign vga.frame_start_o = frameStart_q;

endmodule

// File: doc/vga_timer.md
Name: vga_timer

Overview:
- Generates VGA 640x480@60 raster timing: horizontal/vertical position counters, sync pulses and a visible-area flag.
- Sits directly upstream of every sprite/text object (title, dino, obstacles). Those objects take position_x_o/position_y_o on their pixel_x_i/pixel_y_i inputs and return a combinational pixel bit.
- The top level composites the object pixels and registers RGB together with the syncs from this block.

Parameters:
- HVisible, 640, visible pixels per line
- HFront, 16, horizontal front porch (pixels)
- HSync, 96, hsync pulse width (pixels)
- HBack, 48, horizontal back porch (pixels)
- VVisible, 480, visible lines per frame
- VFront, 10, vertical front porch (lines)
- VSync, 2, vsync pulse width (lines)
- VBack, 33, vertical back porch (lines)

Ports:
- clk_i  input  1  clock (25 MHz pixel clock; 100 MHz when VGA_TIMER_CLK_DIV_EN)
- rst_ni  input  1  reset, asynchronous, active-low
- position_x_o  output  10  current column, 0..HTotal-1
- position_y_o  output  10  current line, 0..VTotal-1
- visible_o  output  1  high when x<HVisible and y<VVisible
- hsync_o  output  1  horizontal sync, active-low
- vsync_o  output  1  vertical sync, active-low
- frame_start_o  output  1  one-clk pulse on the wrap to (0,0)

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous, active-low.
- Derived constants:
  - HTotal = HVisible+HFront+HSync+HBack = 800.
  - VTotal = VVisible+VFront+VSync+VBack = 525.
  - Both must be ≤1024. An elaboration-time check fails otherwise.
- Counters: x and y are 10-bit registers, advanced on a pixel tick.
  - Without the optional feature, pixel tick = every clk.
  - On a tick: if x==HTotal-1, x←0, and y←(y==VTotal-1 ? 0 : y+1). Otherwise x←x+1, y unchanged.
  - No other wrap condition. Counters never exceed HTotal-1 / VTotal-1.
- Position outputs: position_x_o = x and position_y_o = y, driven directly from the registers.
- Decoded outputs: registered, updated on the same edge as the counters. They are computed from next-state x/y, so they are cycle-aligned with position_x_o/position_y_o (zero relative latency).
  - hsync_o = 0 iff HVisible+HFront ≤ x < HVisible+HFront+HSync, i.e. x in 656..751.
  - vsync_o = 0 iff VVisible+VFront ≤ y < VVisible+VFront+VSync, i.e. y in 490..491.
  - visible_o = (x<HVisible) && (y<VVisible).
  - frame_start_o = 1 only for the clk in which counters hold (0,0) immediately after the (HTotal-1,VTotal-1) tick.
  - frame_start_o is not asserted for (0,0) coming out of reset.
- Reset values (asynchronous on rst_ni=0; all hold while low):
  - x=0, y=0
  - visible_o=1
  - hsync_o=1, vsync_o=1
  - frame_start_o=0
- Reset release: the first tick after release moves to (1,0).
- Reset mid-frame: immediately forces the reset values. No partial-line completion.
- Sync overlap: hsync continues toggling every line during vsync lines 490–491.
- Porch/sync lines: visible_o=0 for all of y≥480 regardless of x.

Optional Feature:
- Macro: VGA_TIMER_CLK_DIV_EN.
- Defined:
  - A 2-bit prescaler (reset 0) counts every clk. Pixel tick = prescaler==3, so counters advance once per 4 clks (100 MHz in → 25 MHz pixel rate).
  - Decoded outputs hold between ticks.
  - frame_start_o is high for exactly one clk: the clk after the wrap tick.
- Undefined: no prescaler; tick every clk; behaviour as above.

Test Plan:
- Reset: hold rst_ni=0 for 5 clks → x=0, y=0, hsync_o=1, vsync_o=1, visible_o=1, frame_start_o=0. Release, 1 clk → x=1, y=0.
- Line timing: run from reset → visible_o falls when x=640. hsync_o=0 for exactly x=656..751 (96 clks). x wraps 799→0 and y increments 0→1 on the same edge.
- Frame timing: run 800*525=420000 clks → vsync_o=0 for exactly lines 490–491 (1600 clks). frame_start_o pulses once, at (0,0), on clk 420000. No pulse at clk 0.
- Async reset mid-frame: assert rst_ni=0 at (300,200) between clock edges → outputs go to reset values before the next edge. After release, counting restarts from (0,0).
- Downstream alignment: connect to a title object. Check pixel_o is sampled only while visible_o=1, and that position_y_o=70 is reached exactly 70*800 clks after frame start.
- With VGA_TIMER_CLK_DIV_EN: x advances every 4 clks. A full line takes 3200 clks. frame_start_o width = 1 clk at 1680000-clk period.
